// File: rtl/pulse_meter.sv
// Measures the length of each high pulse on `in` in clock cycles and offers the
// saturating count to a consumer over the rfd / dav_ handshake.
//
// state   | meaning
// S_ARM   | waiting for in=0 so a pulse already in progress is never measured
// S_IDLE  | line low, waiting for the first high sample
// S_COUNT | counting high samples, saturating at 2^W-1
// S_OFFER | data holds the length, waiting for rfd=1
// S_ACK   | dav_ low, waiting for rfd=0
module pulse_meter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in,
  input  logic         rfd,
  output logic         dav_,
  output logic [W-1:0] data
);

  typedef enum logic [2:0] {
    S_ARM,
    S_IDLE,
    S_COUNT,
    S_OFFER,
    S_ACK
  } state_t;

  localparam logic [W-1:0] COUNT_MAX = '1;

  state_t       state, state_nxt;
  logic [W-1:0] count, count_nxt;
  logic [W-1:0] data_nxt;
  logic         dav_nxt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_ARM;
      count <= '0;
      data  <= '0;
      dav_  <= 1'b1;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      data  <= data_nxt;
      dav_  <= dav_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    data_nxt  = data;
    dav_nxt   = dav_;
    case (state)
      S_ARM: begin
        if (!in) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (in) begin
          count_nxt = {{(W-1){1'b0}}, 1'b1};
          state_nxt = S_COUNT;
        end
      end
      S_COUNT: begin
        if (in) begin
          // Saturate rather than wrap so a long pulse never reads as short.
          if (count != COUNT_MAX) count_nxt = count + 1'b1;
        end else begin
          data_nxt  = count;
          state_nxt = S_OFFER;
        end
      end
      S_OFFER: begin
        if (rfd) begin
          dav_nxt   = 1'b0;
          state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        if (!rfd) begin
          dav_nxt   = 1'b1;
          state_nxt = S_ARM;
        end
      end
      default: begin
        state_nxt = S_ARM;
      end
    endcase
  end

endmodule

// File: tb/tb_pulse_meter.sv
// Self-checking bench for pulse_meter: random pulse lengths and handshake delays
// compared against expected lengths min(N, 2^W-1) and handshake timing.
module tb_pulse_meter;
  localparam int W = 8;
  localparam int MAXV = (1 << W) - 1;

  logic         clock = 1'b0;
  logic         reset;
  logic         in;
  logic         rfd;
  logic         dav_;
  logic [W-1:0] data;

  int checks = 0;
  int failures = 0;

  pulse_meter #(.W(W)) dut (
    .clock(clock),
    .reset(reset),
    .in   (in),
    .rfd  (rfd),
    .dav_ (dav_),
    .data (data)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int model_len(input int n);
    return (n > MAXV) ? MAXV : n;
  endfunction

  // Holds in high for exactly n sampling edges, then drops it (not yet sampled).
  task automatic drive_pulse(input int n);
    in = 1'b1;
    repeat (n) tick();
    in = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in = 1'b0; rfd = 1'b0;
    #2;
    checks++;
    if (dav_ !== 1'b1) begin failures++; $display("FAIL reset_dav: got %b expected 1", dav_); end
    checks++;
    if (data !== '0) begin failures++; $display("FAIL reset_data: got %0d expected 0", data); end
    tick();
    reset = 1'b0;
    tick();
    rfd = 1'b1;
    drive_pulse(5);
    tick();
    checks++;
    if (data !== 8'(5)) begin failures++; $display("FAIL reset_first_len: got %0d expected 5", data); end
    tick();
    checks++;
    if (dav_ !== 1'b0) begin failures++; $display("FAIL reset_first_dav: got %b expected 0", dav_); end
    rfd = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_basic();
    int n;
    for (int i = 0; i < 8; i++) begin
      n = (i == 0) ? 3 : (i == 1) ? 1 : int'($urandom_range(1, 20));
      rfd = 1'b1;
      drive_pulse(n);
      tick();
      checks++;
      if (data !== 8'(model_len(n)) || dav_ !== 1'b1) begin
        failures++; $display("FAIL basic_len: got data=%0d dav_=%b expected data=%0d dav_=1", data, dav_, model_len(n));
      end
      tick();
      checks++;
      if (dav_ !== 1'b0 || data !== 8'(model_len(n))) begin
        failures++; $display("FAIL basic_dav_fall: got dav_=%b data=%0d expected dav_=0 data=%0d", dav_, data, model_len(n));
      end
      rfd = 1'b0;
      tick();
      checks++;
      if (dav_ !== 1'b1) begin failures++; $display("FAIL basic_dav_rise: got %b expected 1", dav_); end
      tick();
    end
  endtask

  task automatic test_slow_consumer();
    int n, w;
    for (int i = 0; i < 4; i++) begin
      n = (i == 0) ? 7 : int'($urandom_range(1, 40));
      w = (i == 0) ? 10 : int'($urandom_range(1, 12));
      rfd = 1'b0;
      drive_pulse(n);
      tick();
      repeat (w) begin
        checks++;
        if (dav_ !== 1'b1 || data !== 8'(model_len(n))) begin
          failures++; $display("FAIL slow_hold: got dav_=%b data=%0d expected dav_=1 data=%0d", dav_, data, model_len(n));
        end
        tick();
      end
      rfd = 1'b1;
      tick();
      checks++;
      if (dav_ !== 1'b0 || data !== 8'(model_len(n))) begin
        failures++; $display("FAIL slow_dav_fall: got dav_=%b data=%0d expected dav_=0 data=%0d", dav_, data, model_len(n));
      end
      rfd = 1'b0;
      tick();
      checks++;
      if (dav_ !== 1'b1) begin failures++; $display("FAIL slow_dav_rise: got %b expected 1", dav_); end
      tick();
    end
  endtask

  task automatic test_saturation();
    int lens[5];
    lens[0] = 300; lens[1] = 255; lens[2] = 256; lens[3] = 254;
    lens[4] = int'($urandom_range(257, 700));
    foreach (lens[i]) begin
      rfd = 1'b1;
      drive_pulse(lens[i]);
      tick();
      checks++;
      if (data !== 8'(model_len(lens[i]))) begin
        failures++; $display("FAIL sat_len_%0d: got %0d expected %0d", lens[i], data, model_len(lens[i]));
      end
      tick();
      rfd = 1'b0;
      tick();
      tick();
    end
  endtask

  task automatic test_dropped();
    int n, d;
    for (int i = 0; i < 3; i++) begin
      n = int'($urandom_range(1, 30));
      d = (i == 0) ? 4 : int'($urandom_range(1, 10));
      rfd = 1'b1;
      drive_pulse(n);
      tick();
      tick();
      in = 1'b1;
      repeat (d) begin
        tick();
        checks++;
        if (dav_ !== 1'b0 || data !== 8'(model_len(n))) begin
          failures++; $display("FAIL drop_hold: got dav_=%b data=%0d expected dav_=0 data=%0d", dav_, data, model_len(n));
        end
      end
      in = 1'b0;
      tick();
      rfd = 1'b0;
      tick();
      checks++;
      if (dav_ !== 1'b1 || data !== 8'(model_len(n))) begin
        failures++; $display("FAIL drop_release: got dav_=%b data=%0d expected dav_=1 data=%0d", dav_, data, model_len(n));
      end
      tick();
      rfd = 1'b1;
      drive_pulse(2);
      tick();
      checks++;
      if (data !== 8'(2)) begin failures++; $display("FAIL drop_next_len: got %0d expected 2", data); end
      tick();
      rfd = 1'b0;
      tick();
      tick();
    end
  endtask

  // in rises on the same edge that returns to S_ARM: that pulse must not be measured.
  task automatic test_arm_edge();
    int n, k, m;
    n = int'($urandom_range(1, 30));
    k = int'($urandom_range(1, 8));
    m = int'($urandom_range(1, 30));
    rfd = 1'b1;
    drive_pulse(n);
    tick();
    tick();
    rfd = 1'b0;
    in  = 1'b1;
    tick();
    rfd = 1'b1;
    repeat (k) tick();
    in = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (dav_ !== 1'b1 || data !== 8'(model_len(n))) begin
      failures++; $display("FAIL arm_edge_no_xfer: got dav_=%b data=%0d expected dav_=1 data=%0d", dav_, data, model_len(n));
    end
    drive_pulse(m);
    tick();
    checks++;
    if (data !== 8'(m)) begin failures++; $display("FAIL arm_edge_next_len: got %0d expected %0d", data, m); end
    tick();
    rfd = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    n = int'($urandom_range(1, 30));
    rfd = 1'b1;
    drive_pulse(n);
    tick();
    tick();
    // dav_ is low here; reset mid-handshake must raise it without a clock edge.
    #2 reset = 1'b1;
    #1;
    checks++;
    if (dav_ !== 1'b1 || data !== '0) begin
      failures++; $display("FAIL reset_in_ack: got dav_=%b data=%0d expected dav_=1 data=0", dav_, data);
    end
    #2 reset = 1'b0;
    rfd = 1'b0;
    tick();
    tick();
    rfd = 1'b1;
    drive_pulse(n);
    tick();
    tick();
    rfd = 1'b0;
    tick();
    tick();
    in = 1'b1;
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (dav_ !== 1'b1 || data !== '0) begin
      failures++; $display("FAIL reset_in_count: got dav_=%b data=%0d expected dav_=1 data=0", dav_, data);
    end
    // Release while in is still high: the remainder of this pulse is not measured.
    #2 reset = 1'b0;
    rfd = 1'b1;
    repeat (4) begin
      tick();
      checks++;
      if (dav_ !== 1'b1) begin failures++; $display("FAIL midstart_hold: got dav_=%b expected 1", dav_); end
    end
    in = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (dav_ !== 1'b1 || data !== '0) begin
      failures++; $display("FAIL midstart_no_xfer: got dav_=%b data=%0d expected dav_=1 data=0", dav_, data);
    end
    drive_pulse(6);
    tick();
    checks++;
    if (data !== 8'(6)) begin failures++; $display("FAIL midstart_next_len: got %0d expected 6", data); end
    tick();
    checks++;
    if (dav_ !== 1'b0) begin failures++; $display("FAIL midstart_dav: got %b expected 0", dav_); end
    rfd = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1; in = 1'b0; rfd = 1'b0;
    test_reset();
    test_basic();
    test_slow_consumer();
    test_saturation();
    test_dropped();
    test_arm_edge();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
